// File: rtl/img_stream_tx.sv
// Image stream transmitter: turns a valid/ready pixel source into a vsync/href/gray
// camera-style interface with programmable lead, horizontal blank and tail timing.
module img_stream_tx #(
  parameter int unsigned IMG_HDISP = 512,
  parameter int unsigned IMG_VDISP = 512,
  parameter int unsigned VS_TO_HS  = 5,
  parameter int unsigned H_BLANK   = 10,
  parameter int unsigned V_TAIL    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_gray,
  output logic       per_img_vsync,
  output logic       per_img_href,
  output logic [7:0] per_img_gray,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned ColW = $clog2(IMG_HDISP) + 1;
  localparam int unsigned RowW = $clog2(IMG_VDISP) + 1;
  localparam int unsigned TMax01 = (VS_TO_HS > H_BLANK) ? VS_TO_HS : H_BLANK;
  localparam int unsigned TMax   = (TMax01 > V_TAIL) ? TMax01 : V_TAIL;
  localparam int unsigned TimW   = $clog2(TMax) + 1;

  localparam logic [ColW-1:0] ColLast   = ColW'(IMG_HDISP - 1);
  localparam logic [RowW-1:0] RowLast   = RowW'(IMG_VDISP - 1);
  localparam logic [TimW-1:0] LeadLast  = TimW'(VS_TO_HS - 1);
  localparam logic [TimW-1:0] BlankLast = TimW'(H_BLANK - 1);
  localparam logic [TimW-1:0] TailLast  = TimW'(V_TAIL - 1);

  typedef enum logic [2:0] {StIdle, StLead, StActive, StHblank, StTail} state_e;

  state_e          state_q;
  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;
  logic [TimW-1:0] tim_q;
  logic            href_q;
  logic [7:0]      gray_q;
  logic            done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      tim_q   <= '0;
      href_q  <= 1'b0;
      gray_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      href_q <= 1'b0;
      gray_q <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            state_q <= StLead;
            col_q   <= '0;
            row_q   <= '0;
            tim_q   <= '0;
          end
        end
        StLead: begin
          if (tim_q == LeadLast) begin
            state_q <= StActive;
            tim_q   <= '0;
          end else begin
            tim_q <= tim_q + TimW'(1);
          end
        end
        StActive: begin
          // Only accepted pixels advance the column, so source stalls stretch the row.
          if (s_valid) begin
            href_q <= 1'b1;
            gray_q <= s_gray;
            if (col_q == ColLast) begin
              col_q   <= '0;
              tim_q   <= '0;
              state_q <= (row_q == RowLast) ? StTail : StHblank;
            end else begin
              col_q <= col_q + ColW'(1);
            end
          end
        end
        StHblank: begin
          if (tim_q == BlankLast) begin
            state_q <= StActive;
            tim_q   <= '0;
            col_q   <= '0;
            row_q   <= row_q + RowW'(1);
          end else begin
            tim_q <= tim_q + TimW'(1);
          end
        end
        StTail: begin
          if (tim_q == TailLast) begin
            state_q <= StIdle;
            tim_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            tim_q <= tim_q + TimW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pure decodes of the state register; no input reaches these outputs.
  assign s_ready       = (state_q == StActive);
  assign per_img_vsync = (state_q != StIdle);
  assign busy          = (state_q != StIdle);
  assign per_img_href  = href_q;
  assign per_img_gray  = gray_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_img_stream_tx.sv
// Randomized bench for img_stream_tx: a per-frame transfer schedule is derived from
// the timing rules and every output cycle is compared against it.
module tb_img_stream_tx;

  localparam int HD   = 4;
  localparam int VD   = 3;
  localparam int VSL  = 5;
  localparam int HB   = 10;
  localparam int VT   = 2;
  localparam int NPIX = HD * VD;
  localparam int MAXR = 512;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_gray;
  logic       per_img_vsync;
  logic       per_img_href;
  logic [7:0] per_img_gray;
  logic       busy;
  logic       frame_done;

  logic [12:0] outs;
  assign outs = {per_img_vsync, busy, s_ready, frame_done, per_img_href, per_img_gray};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  img_stream_tx #(
    .IMG_HDISP(HD),
    .IMG_VDISP(VD),
    .VS_TO_HS (VSL),
    .H_BLANK  (HB),
    .V_TAIL   (VT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_gray       (s_gray),
    .per_img_vsync(per_img_vsync),
    .per_img_href (per_img_href),
    .per_img_gray (per_img_gray),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference schedule, indexed by cycle relative to the frame_start cycle.
  bit         valid_at[MAXR];
  bit         e_href[MAXR];
  bit         e_rdy[MAXR];
  logic [7:0] e_gray[MAXR];
  logic [7:0] pix[NPIX];
  int         end_rel;

  task automatic build_model(input int mode);
    int t;
    int k;
    for (int r = 0; r < MAXR; r++) begin
      case (mode)
        0:       valid_at[r] = 1'b1;
        1:       valid_at[r] = !(r >= 22 && r <= 24);
        default: valid_at[r] = (r > MAXR / 2) ? 1'b1 : ($urandom_range(3) != 0);
      endcase
      e_href[r] = 1'b0;
      e_rdy[r]  = 1'b0;
      e_gray[r] = 8'h00;
    end
    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom);
    // Rows open after the lead; each pixel takes the next cycle the source is valid.
    t = VSL + 1;
    k = 0;
    for (int r = 0; r < VD; r++) begin
      for (int c = 0; c < HD; c++) begin
        while (!valid_at[t]) begin
          e_rdy[t] = 1'b1;
          t++;
        end
        e_rdy[t]      = 1'b1;
        e_href[t + 1] = 1'b1;
        e_gray[t + 1] = pix[k];
        k++;
        t++;
      end
      if (r < VD - 1) t += HB;
    end
    end_rel = t + VT;
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b0;
      s_valid     = 1'($urandom_range(1));
      s_gray      = 8'($urandom);
      @(negedge clk);
      check(name, 32'(outs), 32'h0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input int mode, input bit started, input bit b2b_next,
                           input int rst_rel, input string name,
                           output int first_href, output int done_rel, output int npix);
    int          idx;
    bit          xfer;
    bit          ev;
    logic [12:0] exp_v;
    build_model(mode);
    idx        = 0;
    first_href = -1;
    done_rel   = -1;
    npix       = 0;
    for (int rel = (started ? 1 : 0); rel <= end_rel; rel++) begin
      if (rel == 0) frame_start = 1'b1;
      else if (rel == end_rel) frame_start = b2b_next;
      else frame_start = ($urandom_range(7) == 0);
      rst_n   = (rel != rst_rel);
      s_valid = valid_at[rel];
      s_gray  = (idx < NPIX) ? pix[idx] : 8'($urandom);
      @(negedge clk);
      ev    = (rel >= 1 && rel < end_rel);
      exp_v = {ev, ev, e_rdy[rel], (rel == end_rel), e_href[rel], e_gray[rel]};
      check($sformatf("%s rel%0d", name, rel), 32'(outs), 32'(exp_v));
      if (per_img_href) begin
        npix++;
        if (first_href < 0) first_href = rel;
      end
      if (frame_done) done_rel = rel;
      xfer = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (xfer) idx++;
      if (rel == rst_rel) begin
        rst_n       = 1'b1;
        frame_start = 1'b0;
        s_valid     = 1'b1;
        @(negedge clk);
        check($sformatf("%s after reset", name), 32'(outs), 32'h0);
        @(posedge clk);
        #1;
        break;
      end
    end
  endtask

  initial begin
    int fh, dr, np;
    bit cont, nb;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    s_valid     = 1'b0;
    s_gray      = 8'h00;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      frame_start = 1'b1;
      s_valid     = 1'b1;
      s_gray      = 8'hA5;
      @(negedge clk);
      check("reset outputs", 32'(outs), 32'h0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    idle(2, "idle start");

    run_frame(0, 1'b0, 1'b0, -1, "nominal", fh, dr, np);
    check("nominal first href", fh, 7);
    check("nominal frame_done", dr, 40);
    check("nominal pixels", np, NPIX);
    idle(2, "idle nominal");

    run_frame(1, 1'b0, 1'b0, -1, "stall", fh, dr, np);
    check("stall first href", fh, 7);
    check("stall frame_done", dr, 43);
    check("stall pixels", np, NPIX);
    idle(1, "idle stall");

    run_frame(0, 1'b0, 1'b0, 22, "rstmid", fh, dr, np);
    check("rstmid no done", dr, -1);
    idle(4, "post reset");
    run_frame(0, 1'b0, 1'b0, -1, "clean", fh, dr, np);
    check("clean frame_done", dr, 40);
    check("clean pixels", np, NPIX);
    idle(1, "idle clean");

    run_frame(0, 1'b0, 1'b1, -1, "b2b_a", fh, dr, np);
    check("b2b_a frame_done", dr, 40);
    run_frame(0, 1'b1, 1'b0, -1, "b2b_b", fh, dr, np);
    check("b2b_b first href", fh, 7);
    check("b2b_b frame_done", dr, 40);
    check("b2b_b pixels", np, NPIX);
    idle(2, "idle b2b");

    cont = 1'b0;
    for (int f = 0; f < 20; f++) begin
      nb = (f < 19) ? 1'($urandom_range(1)) : 1'b0;
      run_frame(2, cont, nb, -1, $sformatf("rnd%0d", f), fh, dr, np);
      check($sformatf("rnd%0d pixels", f), np, NPIX);
      cont = nb;
      if (!nb) idle(1 + $urandom_range(2), "idle rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
